// File: rtl/cache_pkg.sv
// cache_pkg: shared types and default widths for the direct-mapped cache controller.
//   DEF_INDEX_COUNT / DEF_DATA_W / DEF_TAG_W : default geometry
//   cache_ctrl_state_t                       : controller FSM states
//   cache_line_t                             : {valid, tag, data} line as written to the array
package cache_pkg;
  localparam int DEF_INDEX_COUNT = 256;
  localparam int DEF_DATA_W = 11;
  localparam int DEF_TAG_W = 20;
  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    RD_HIT,
    MEM_REQ,
    MEM_WAIT,
    FILL,
    RESP
  } cache_ctrl_state_t;
  typedef struct packed {
    logic valid;
    logic [DEF_TAG_W-1:0] tag;
    logic [DEF_DATA_W-1:0] data;
  } cache_line_t;
endpackage

// File: rtl/cache_ctrl_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping.
//   clk, rst (async, active-low) : clock / reset (clears count)
//   inc                          : add one this cycle
//   count                        : current count
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] count_q, count_d;
  always_comb count_d = (inc && !(&count_q)) ? count_q + 1'b1 : count_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) count_q <= '0;
    else count_q <= count_d;
  assign count = count_q;
endmodule

// File: rtl/cache_ctrl.sv
// cache_ctrl: requester-side controller for a direct-mapped, write-through, write-allocate cache.
//   clk, rst (async, active-low)
//   req_*        : CPU load/store request (req_ready high only while idle)
//   resp_*       : one-cycle completion pulse with load data and hit flag
//   cache_enable, rd_wr_sel, index_sel, write_index, read_data, cache_tag : cache array port
//   mem_req_*, mem_wdata, mem_resp_valid, mem_rdata : memory bus
//   hit_count, miss_count : saturating statistics, present only with CACHE_CTRL_STATS_EN
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int INDEX_COUNT = DEF_INDEX_COUNT,
  parameter int DATA_W = DEF_DATA_W,
  parameter int TAG_W = DEF_TAG_W,
  localparam int IDX_W = $clog2(INDEX_COUNT),
  localparam int ADDR_W = TAG_W + IDX_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [DATA_W-1:0]       req_wdata,
  output logic                    resp_valid,
  output logic [DATA_W-1:0]       resp_rdata,
  output logic                    resp_hit,
  output logic                    cache_enable,
  output logic                    rd_wr_sel,
  output logic [IDX_W-1:0]        index_sel,
  output logic [TAG_W+DATA_W:0]   write_index,
  input  logic [DATA_W-1:0]       read_data,
  input  logic [TAG_W-1:0]        cache_tag,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic                    mem_req_we,
  output logic [ADDR_W-1:0]       mem_req_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic                    mem_resp_valid,
  input  logic [DATA_W-1:0]       mem_rdata
`ifdef CACHE_CTRL_STATS_EN
  , output logic [31:0]           hit_count,
  output logic [31:0]             miss_count
`endif
);
  cache_ctrl_state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic we_q, we_d, hit_q, hit_d, hit;
  logic [DATA_W-1:0] wdata_q, wdata_d, data_q, data_d;
  logic [INDEX_COUNT-1:0] valid_q, valid_d;
  logic req_ready_q, req_ready_d, resp_valid_q, resp_valid_d, resp_hit_q, resp_hit_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d, mem_wdata_q, mem_wdata_d;
  logic mem_req_valid_q, mem_req_valid_d, mem_req_we_q, mem_req_we_d;
  logic [ADDR_W-1:0] mem_req_addr_q, mem_req_addr_d;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  assign idx = addr_q[IDX_W-1:0];
  assign tag = addr_q[ADDR_W-1:IDX_W];
  // cache_tag is combinational on index_sel, so the lookup and the array strobe
  // must be decided in the same LOOKUP cycle rather than from a registered copy.
  assign hit = valid_q[idx] && cache_tag == tag;
  assign index_sel = idx;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    we_d = we_q;
    wdata_d = wdata_q;
    hit_d = hit_q;
    data_d = data_q;
    valid_d = valid_q;
    cache_enable = 1'b0;
    rd_wr_sel = 1'b0;
    write_index = '0;
    case (state_q)
      IDLE:
        if (req_valid) begin
          addr_d = req_addr;
          we_d = req_we;
          wdata_d = req_wdata;
          state_d = LOOKUP;
        end
      LOOKUP: begin
        hit_d = hit;
        if (we_q) begin
          cache_enable = 1'b1;
          rd_wr_sel = 1'b1;
          write_index = {1'b1, tag, wdata_q};
          valid_d[idx] = 1'b1;
          state_d = MEM_REQ;
        end else if (hit) begin
          cache_enable = 1'b1;
          state_d = RD_HIT;
        end else begin
          state_d = MEM_REQ;
        end
      end
      RD_HIT: begin
        data_d = read_data;
        state_d = RESP;
      end
      MEM_REQ:
        if (mem_req_ready) state_d = we_q ? RESP : MEM_WAIT;
      MEM_WAIT:
        if (mem_resp_valid) begin
          data_d = mem_rdata;
          state_d = FILL;
        end
      FILL: begin
        cache_enable = 1'b1;
        rd_wr_sel = 1'b1;
        write_index = {1'b1, tag, data_q};
        valid_d[idx] = 1'b1;
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
    // Bus and response outputs are registered from the next state so they are
    // glitch-free and line up exactly with the state they belong to.
    req_ready_d = state_d == IDLE;
    resp_valid_d = state_d == RESP;
    resp_hit_d = state_d == RESP && hit_d;
    resp_rdata_d = (state_d == RESP && !we_d) ? data_d : '0;
    mem_req_valid_d = state_d == MEM_REQ;
    mem_req_we_d = mem_req_valid_d && we_d;
    mem_req_addr_d = mem_req_valid_d ? addr_d : '0;
    mem_wdata_d = mem_req_we_d ? wdata_d : '0;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      we_q <= 1'b0;
      wdata_q <= '0;
      hit_q <= 1'b0;
      data_q <= '0;
      valid_q <= '0;
      req_ready_q <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_hit_q <= 1'b0;
      resp_rdata_q <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_we_q <= 1'b0;
      mem_req_addr_q <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      we_q <= we_d;
      wdata_q <= wdata_d;
      hit_q <= hit_d;
      data_q <= data_d;
      valid_q <= valid_d;
      req_ready_q <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q <= resp_hit_d;
      resp_rdata_q <= resp_rdata_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_we_q <= mem_req_we_d;
      mem_req_addr_q <= mem_req_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  assign req_ready = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_hit = resp_hit_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_we = mem_req_we_q;
  assign mem_req_addr = mem_req_addr_q;
  assign mem_wdata = mem_wdata_q;
`ifdef CACHE_CTRL_STATS_EN
  sat_counter #(.WIDTH(32)) u_hit_cnt (
    .clk(clk),
    .rst(rst),
    .inc(resp_valid_q && resp_hit_q),
    .count(hit_count)
  );
  sat_counter #(.WIDTH(32)) u_miss_cnt (
    .clk(clk),
    .rst(rst),
    .inc(resp_valid_q && !resp_hit_q),
    .count(miss_count)
  );
`endif
endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed bench for cache_ctrl with a behavioural cache array and hand-driven memory.
module tb_cache_ctrl;
  import cache_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req_valid = 1'b0, req_we = 1'b0;
  logic [27:0] req_addr = '0;
  logic [10:0] req_wdata = '0;
  logic req_ready, resp_valid, resp_hit, cache_enable, rd_wr_sel;
  logic [10:0] resp_rdata, mem_wdata;
  logic [7:0] index_sel;
  logic [31:0] write_index;
  logic [10:0] read_data = '0;
  logic [19:0] cache_tag;
  logic mem_req_valid, mem_req_we;
  logic mem_req_ready = 1'b0, mem_resp_valid = 1'b0;
  logic [27:0] mem_req_addr;
  logic [10:0] mem_rdata = '0;
`ifdef CACHE_CTRL_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif
  logic [19:0] tag_mem [256];
  logic [10:0] data_mem [256];
  logic [31:0] last_wr = '0;
  logic [7:0] last_idx = '0;
  int wr_cnt = 0;
  int vectors = 0;
  int errors = 0;

  cache_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit),
    .cache_enable(cache_enable), .rd_wr_sel(rd_wr_sel), .index_sel(index_sel),
    .write_index(write_index), .read_data(read_data), .cache_tag(cache_tag),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_wdata(mem_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
`ifdef CACHE_CTRL_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  assign cache_tag = tag_mem[index_sel];
  always @(posedge clk)
    if (cache_enable) begin
      if (rd_wr_sel) begin
        wr_cnt <= wr_cnt + 1;
        last_wr <= write_index;
        last_idx <= index_sel;
        tag_mem[index_sel] <= write_index[30:11];
        data_mem[index_sel] <= write_index[10:0];
      end else begin
        read_data <= data_mem[index_sel];
      end
    end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic xact(input logic we, input logic [27:0] addr, input logic [10:0] wd,
                      input logic exp_hit, input logic [10:0] exp_rd, input logic [10:0] mdata,
                      input int rdy_dly, input logic same);
    int n, held, hs;
    logic mem_seen, done;
    cache_line_t exp_line;
    @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    req_valid = 1; req_we = we; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0;
    n = 1; held = 0; hs = -1; mem_seen = 0; done = 0;
    while (!done && n < 60) begin
      mem_req_ready = 0;
      mem_resp_valid = 0;
      if (hs >= 0 && !we && n == hs + 1) begin
        mem_resp_valid = 1;
        mem_rdata = mdata;
      end
      if (mem_req_valid) begin
        mem_seen = 1;
        check("mem_addr", mem_req_addr, addr);
        check("mem_we", mem_req_we, we);
        if (we) check("mem_wdata", mem_wdata, wd);
        check("req_ready_busy", req_ready, 0);
        if (held == rdy_dly) begin
          mem_req_ready = 1;
          hs = n;
          if (same && !we) begin
            mem_resp_valid = 1;
            mem_rdata = mdata;
          end
        end else held++;
      end
      if (resp_valid) begin
        done = 1;
        check("resp_rdata", resp_rdata, exp_rd);
        check("resp_hit", resp_hit, exp_hit);
        if (exp_hit && !we) check("hit_latency", n, 3);
      end else begin
        @(negedge clk);
        n++;
      end
    end
    mem_req_ready = 0;
    mem_resp_valid = 0;
    check("resp_seen", done, 1);
    check("mem_req_issued", mem_seen, we || !exp_hit);
    if (we || !exp_hit) begin
      exp_line = '{valid: 1'b1, tag: addr[27:8], data: we ? wd : mdata};
      check("line_written", last_wr, exp_line);
      check("line_index", last_idx, addr[7:0]);
    end
    @(negedge clk);
    check("resp_pulse_1cyc", resp_valid, 0);
    check("req_ready_back", req_ready, 1);
  endtask

  initial begin
    int n, wr0;
    for (int i = 0; i < 256; i++) begin
      tag_mem[i] = '0;
      data_mem[i] = '0;
    end
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_resp_hit", resp_hit, 0);
    check("rst_cache_en", cache_enable, 0);
    check("rst_rd_wr_sel", rd_wr_sel, 0);
    check("rst_index_sel", index_sel, 0);
    check("rst_write_index", write_index, 0);
    check("rst_mem_valid", mem_req_valid, 0);
    check("rst_mem_we", mem_req_we, 0);
    check("rst_mem_addr", mem_req_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    rst = 1;
    // 1: cold miss, refill
    xact(0, 28'h0000105, 0, 0, 11'h2AB, 11'h2AB, 0, 0);
    // 2: hit
    xact(0, 28'h0000105, 0, 1, 11'h2AB, 0, 0, 0);
    // 3: conflicting tag evicts, original tag misses again
    xact(0, 28'h0000205, 0, 0, 11'h155, 11'h155, 0, 0);
    xact(0, 28'h0000105, 0, 0, 11'h3C3, 11'h3C3, 0, 0);
`ifdef CACHE_CTRL_STATS_EN
    check("hit_count", hit_count, 1);
    check("miss_count", miss_count, 3);
`endif
    // 4: store to top index with stalled memory, then load hit
    xact(1, 28'hFFFFFFF, 11'h7FF, 0, 0, 0, 5, 0);
    xact(0, 28'hFFFFFFF, 0, 1, 11'h7FF, 0, 0, 0);
    // index 0 with ready and response in the same cycle, then hit
    xact(0, 28'h1234500, 0, 0, 11'h123, 11'h123, 0, 1);
    xact(0, 28'h1234500, 0, 1, 11'h123, 0, 2, 0);
    // store hit over an existing line
    xact(1, 28'h1234500, 11'h456, 1, 0, 0, 1, 0);
    xact(0, 28'h1234500, 0, 1, 11'h456, 0, 0, 0);
    // 5: reset while waiting for memory
    @(negedge clk);
    req_valid = 1; req_we = 0; req_addr = 28'h0000205;
    @(negedge clk);
    req_valid = 0; req_addr = '0;
    n = 0;
    while (!mem_req_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("r5_mem_req", mem_req_valid, 1);
    mem_req_ready = 1;
    @(negedge clk);
    mem_req_ready = 0;
    rst = 0;
    #1;
    check("r5_req_ready", req_ready, 1);
    check("r5_resp_valid", resp_valid, 0);
    check("r5_mem_valid", mem_req_valid, 0);
    check("r5_mem_addr", mem_req_addr, 0);
    check("r5_index_sel", index_sel, 0);
    check("r5_cache_en", cache_enable, 0);
    wr0 = wr_cnt;
    @(negedge clk);
    rst = 1;
    mem_resp_valid = 1;
    mem_rdata = 11'h555;
    repeat (3) begin
      @(negedge clk);
      mem_resp_valid = 0;
      check("r5_no_resp", resp_valid, 0);
      check("r5_no_strobe", cache_enable, 0);
      check("r5_idle", req_ready, 1);
    end
    check("r5_no_write", wr_cnt, wr0);
    xact(0, 28'h0000205, 0, 0, 11'h0E1, 11'h0E1, 0, 0);
    xact(0, 28'hFFFFFFF, 0, 0, 11'h19A, 11'h19A, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
